// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table,
// segment bit positions and the dark pattern used by every digit driver.
package seg_pkg;

  // Bit positions inside the 8-bit segment bus {dp,g,f,e,d,c,b,a}.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high "everything dark" segment pattern.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high glyphs {g,f,e,d,c,b,a}; element 0 is the rightmost entry.
  localparam logic [15:0][6:0] HEX_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Builds the active-high segment bus from a glyph, its decimal point and
  // the blank flag; a blanked digit is fully dark, decimal point included.
  function automatic logic [7:0] seg_pack(
    input logic [6:0] glyph,
    input logic       dp,
    input logic       blank
  );
    logic [7:0] res;
    res = SEG_OFF;
    if (blank) begin
      res = SEG_OFF;
    end else begin
      res[SEG_A]  = glyph[0];
      res[SEG_B]  = glyph[1];
      res[SEG_C]  = glyph[2];
      res[SEG_D]  = glyph[3];
      res[SEG_E]  = glyph[4];
      res[SEG_F]  = glyph[5];
      res[SEG_G]  = glyph[6];
      res[SEG_DP] = dp;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_hex7seg.sv
// Combinational hex nibble to seven-segment glyph decoder (active-high).
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Plain table lookup; every nibble value has an entry.
  always_comb begin
    glyph = HEX_LUT[nibble];
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scan driver. clk_div is treated as data: its
// rising edges (qualified by PLL lock) advance the digit index. Display data
// passes through a staging register and is committed to the shadow register
// only when the index wraps, so a frame never mixes old and new data.
module seg_scan
  import seg_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
)(
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  locked,
  input  logic                  clk_div,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  data_load,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]    IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_BIT0  = N_DIGITS'(1);
  localparam logic [N_DIGITS-1:0] AN_NONE  = N_DIGITS'(0);
  // XOR masks applied last so the internal logic stays active-high.
  localparam logic [N_DIGITS-1:0] AN_POL   = {N_DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]          SEG_POL  = {8{ACTIVE_LOW}};

  // Edge detector and index.
  logic                         clk_div_q_r;
  logic [IDX_W-1:0]             idx_r;
  logic                         step_s;
  logic                         wrap_s;
  logic [IDX_W-1:0]             idx_next_s;

  // Staging (written by data_load) and shadow (what is displayed).
  logic [N_DIGITS-1:0][3:0]     stage_data_r;
  logic [N_DIGITS-1:0]          stage_dp_r;
  logic [N_DIGITS-1:0]          stage_blank_r;
  logic [N_DIGITS-1:0][3:0]     shadow_data_r;
  logic [N_DIGITS-1:0]          shadow_dp_r;
  logic [N_DIGITS-1:0]          shadow_blank_r;
  logic [N_DIGITS-1:0][3:0]     shadow_data_next_s;
  logic [N_DIGITS-1:0]          shadow_dp_next_s;
  logic [N_DIGITS-1:0]          shadow_blank_next_s;

  // Selected digit and the resulting active-high outputs.
  logic [3:0]                   digit_nib_s;
  logic                         digit_dp_s;
  logic                         digit_blank_s;
  logic [6:0]                   glyph_s;
  logic [N_DIGITS-1:0]          an_hi_s;
  logic [7:0]                   seg_hi_s;

  // Output registers.
  logic [N_DIGITS-1:0]          an_r;
  logic [7:0]                   seg_r;
  logic                         frame_start_r;

  assign step_s = clk_div & ~clk_div_q_r & locked;
  assign wrap_s = step_s & (idx_r == IDX_LAST);

  // Next digit index: cleared while unlocked, wraps after the last digit.
  always_comb begin
    idx_next_s = idx_r;
    if (!locked) begin
      idx_next_s = IDX_ZERO;
    end else if (wrap_s) begin
      idx_next_s = IDX_ZERO;
    end else if (step_s) begin
      idx_next_s = idx_r + IDX_ONE;
    end else begin
      idx_next_s = idx_r;
    end
  end

  // Next shadow contents: a wrap commits staging, or the inputs themselves
  // when a load lands in the very same cycle as the wrap.
  always_comb begin
    shadow_data_next_s  = shadow_data_r;
    shadow_dp_next_s    = shadow_dp_r;
    shadow_blank_next_s = shadow_blank_r;
    if (wrap_s && data_load) begin
      shadow_data_next_s  = data_in;
      shadow_dp_next_s    = dp_in;
      shadow_blank_next_s = blank_in;
    end else if (wrap_s) begin
      shadow_data_next_s  = stage_data_r;
      shadow_dp_next_s    = stage_dp_r;
      shadow_blank_next_s = stage_blank_r;
    end else begin
      shadow_data_next_s  = shadow_data_r;
      shadow_dp_next_s    = shadow_dp_r;
      shadow_blank_next_s = shadow_blank_r;
    end
  end

  // Pick the digit that will be active next cycle so the registered
  // outputs line up with the index register.
  always_comb begin
    digit_nib_s   = shadow_data_next_s[idx_next_s];
    digit_dp_s    = shadow_dp_next_s[idx_next_s];
    digit_blank_s = shadow_blank_next_s[idx_next_s];
  end

  hex7seg u_hex7seg (
    .nibble (digit_nib_s),
    .glyph  (glyph_s)
  );

  // Active-high anode and segment values; everything dark while unlocked.
  always_comb begin
    an_hi_s  = AN_NONE;
    seg_hi_s = SEG_OFF;
    if (!locked) begin
      an_hi_s  = AN_NONE;
      seg_hi_s = SEG_OFF;
    end else begin
      an_hi_s  = AN_BIT0 << idx_next_s;
      seg_hi_s = seg_pack(glyph_s, digit_dp_s, digit_blank_s);
    end
  end

  // Edge-detect history and digit index; both clear while unlocked.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_div_q_r <= 1'b0;
      idx_r       <= IDX_ZERO;
    end else if (!locked) begin
      clk_div_q_r <= 1'b0;
      idx_r       <= IDX_ZERO;
    end else begin
      clk_div_q_r <= clk_div;
      idx_r       <= idx_next_s;
    end
  end

  // Staging register: the most recent load wins; kept across lock loss.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      stage_data_r  <= {N_DIGITS{4'h0}};
      stage_dp_r    <= {N_DIGITS{1'b0}};
      stage_blank_r <= {N_DIGITS{1'b1}};
    end else if (data_load) begin
      stage_data_r  <= data_in;
      stage_dp_r    <= dp_in;
      stage_blank_r <= blank_in;
    end else begin
      stage_data_r  <= stage_data_r;
      stage_dp_r    <= stage_dp_r;
      stage_blank_r <= stage_blank_r;
    end
  end

  // Shadow register: only changes on a wrap, so frames never tear.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data_r  <= {N_DIGITS{4'h0}};
      shadow_dp_r    <= {N_DIGITS{1'b0}};
      shadow_blank_r <= {N_DIGITS{1'b1}};
    end else begin
      shadow_data_r  <= shadow_data_next_s;
      shadow_dp_r    <= shadow_dp_next_s;
      shadow_blank_r <= shadow_blank_next_s;
    end
  end

  // Registered pin drivers with the polarity applied last.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      an_r          <= AN_NONE ^ AN_POL;
      seg_r         <= SEG_OFF ^ SEG_POL;
      frame_start_r <= 1'b0;
    end else begin
      an_r          <= an_hi_s ^ AN_POL;
      seg_r         <= seg_hi_s ^ SEG_POL;
      frame_start_r <= wrap_s;
    end
  end

  assign an          = an_r;
  assign seg         = seg_r;
  assign frame_start = frame_start_r;

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed seven-segment display driver. It consumes the divided clock produced by the clock-divider stage as a scan strobe in the `clk_in` domain, steps through N digits, and drives anode and segment lines. It sits directly downstream of the divider. It gates all activity on PLL `locked`. Displayed data is updated only at frame boundaries to avoid tearing.

## Interface
- `N_DIGITS`, 8: number of digits scanned (2..8).
- `ACTIVE_LOW`, 1: 1 means `an`/`seg` are asserted low; 0 means asserted high.
- `clk_in` in 1: system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock. When low, the block behaves as in reset, but synchronously.
- `clk_div` in 1: divider output, registered in the `clk_in` domain; used as data only, never as a clock.
- `data_in` in 4*N_DIGITS: hex nibbles; digit 0 = bits [3:0].
- `dp_in` in N_DIGITS: decimal point per digit.
- `blank_in` in N_DIGITS: 1 means the digit is dark.
- `data_load` in 1: one-cycle strobe that captures `data_in`, `dp_in` and `blank_in` into the staging register.
- `an` out N_DIGITS: digit enables, one-hot when active.
- `seg` out 8: {dp,g,f,e,d,c,b,a}.
- `frame_start` out 1: one-cycle pulse when digit 0 becomes active.

## Operation
- Edge detect: `clk_div_q` registers `clk_div`. `step = clk_div & ~clk_div_q & locked`.
- Digit index `idx` counts 0..N_DIGITS-1 on `step`.
  - At N_DIGITS-1 a `step` wraps it to 0; this is the "wrap step".
- Staging: on `data_load`, copy the inputs into the staging registers. The last load before commit wins.
- Commit: on a wrap step, copy staging into the display shadow.
  - If `data_load` and the wrap step occur in the same cycle, the newly loaded values are committed (bypass).
- Output for digit k = `idx`:
  - `an` has only bit k asserted.
  - `seg` = LUT(shadow nibble k) with dp = shadow dp k.
  - If shadow blank k is set, all `seg` bits are deasserted but `an` bit k stays asserted.
- `ACTIVE_LOW` applies a final inversion to `an` and `seg` only. Internal logic is active-high.
- `locked` low for any cycle: synchronously clear `idx` and `clk_div_q`, deassert all `an`/`seg`, and suppress `frame_start`. Staging and shadow registers are retained.
- No `step` while `locked` is low. The first rising edge of `clk_div` after `locked` rises produces a step.

## Timing
- Reset (`rst_n`=0, asynchronous) values:
  - `idx`=0, `clk_div_q`=0.
  - Staging and shadow registers all 0; blank registers all 1 (dark).
  - `an`, `seg` deasserted: all-ones when `ACTIVE_LOW`=1.
  - `frame_start`=0.
- Latency: `an`/`seg` are registered. They reflect the new `idx` one `clk_in` cycle after the cycle in which `step` is high.
- `frame_start` is registered and coincides with the cycle in which `an` first shows digit 0 after a wrap step.
- Data latency: from `data_load` to visible change, at most one full frame plus one cycle. It is never mid-frame.
- `clk_div` high for a single cycle or for many cycles gives exactly one step per rising edge.
- First display after reset requires a commit. Until the first wrap step, all digits are dark, although `an` still scans.
- Release of `rst_n` is assumed to be synchronised externally. The block imposes no extra constraint.

## Structure
- Package `seg_pkg` holds:
  - The 16-entry hex-to-segment LUT constant (active-high, {g..a}).
  - Segment bit-position constants.
  - `SEG_OFF`.
- Sub-module `hex7seg`: combinational nibble-to-7-bit decoder using the LUT. It is instantiated once, indexed by `idx`.
- The top level holds the edge detector, index counter, staging and shadow registers, and output registers.

## Test plan
- Reset and idle:
  - Stimulus: `rst_n`=0 mid-scan with `ACTIVE_LOW`=1.
  - Response: `an`=8'hFF and `seg`=8'hFF in the same cycle (async); `idx`=0 after release.
- Basic scan:
  - Stimulus: `locked`=1; load `data_in`=32'h76543210 with `dp_in`=0 and `blank_in`=0; drive `clk_div` with period 6.
  - Response: after the first wrap, `an` cycles FE, FD, ... 7F. Digit 0 shows `seg`=8'hC0 ('0'); digit 7 shows 8'hF8 ('7').
- Tear-free update:
  - Stimulus: `data_load` of 32'hFFFFFFFF while `idx`=3.
  - Response: digits 3..7 still show the old values. The new values appear from the cycle of the next `frame_start`.
- Same-cycle load and wrap:
  - Stimulus: `data_load` 32'h00000001 in the exact cycle of the wrap step.
  - Response: digit 0 shows '1' (8'hF9) in the next frame.
- Lock loss:
  - Stimulus: drop `locked` while `idx`=5, then restore it.
  - Response: all outputs are off in the next cycle and there is no step. Scanning resumes at digit 0 on the first `clk_div` rising edge after restore, and the shadow data is intact.
- Blank and dp:
  - Stimulus: `blank_in`=8'h80, `dp_in`=8'h01.
  - Response: digit 7 shows `an` bit 7 low with `seg`=8'hFF. Digit 0 shows `seg` bit 7 low.
